// File: rtl/codec_init_sequencer_if.sv
// Handshake between the codec init sequencer (master) and the I2C bus master (slave).
// The sequencer posts one register write per strobe and the bus master reports completion and ACK status.
interface codec_init_sequencer_if;
  logic        begin_transmition;
  logic [15:0] dataToSend;
  logic [6:0]  receiver_address;
  logic        r_w;
  logic        transmition_over;
  logic        ACK;

  modport master (
    output begin_transmition,
    output dataToSend,
    output receiver_address,
    output r_w,
    input  transmition_over,
    input  ACK
  );

  modport slave (
    input  begin_transmition,
    input  dataToSend,
    input  receiver_address,
    input  r_w,
    output transmition_over,
    output ACK
  );
endinterface

// File: rtl/codec_init_sequencer.sv
// WM8731 power-up sequencer: walks eight fixed register writes through the I2C bus master,
// retrying each entry on NACK or timeout before giving up.
module codec_init_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h1A,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  codec_init_sequencer_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [2:0]                    entry_idx
);

  localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned LAST_IDX = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  // Fixed codec bring-up table: {reg_addr[6:0], reg_data[8:0]}, mic capture over I2S.
  function automatic logic [WORD_W-1:0] table_word(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    table_word = 16'h1E00;
      3'd1:    table_word = 16'h0C79;
      3'd2:    table_word = 16'h0805;
      3'd3:    table_word = 16'h0A00;
      3'd4:    table_word = 16'h0E02;
      3'd5:    table_word = 16'h1000;
      3'd6:    table_word = 16'h0080;
      default: table_word = 16'h1201;
    endcase
  endfunction

  // Next-state and next-output logic; transmition_over takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          data_d  = table_word(IDX_W'(0));
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.transmition_over && bus.ACK) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            data_d  = table_word(idx_q + IDX_W'(1));
            retry_d = '0;
          end
        end else if (bus.transmition_over || (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
          retry_d = retry_q + RETRY_W'(1);
          if (retry_d == RETRY_W'(MAX_RETRY)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    strobe_d = (state_d == S_ISSUE);
    busy_d   = (state_d inside {S_ISSUE, S_WAIT, S_GAP});
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      retry_q  <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.begin_transmition = strobe_q;
  assign bus.dataToSend        = data_q;
  assign bus.receiver_address  = DEV_ADDR;
  assign bus.r_w               = 1'b0;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign entry_idx             = idx_q;

endmodule
